core_run_ctrl: RTL and testbench

- Run controller that sequences the 9-bit-ISA core through one program execution: hold-in-reset, start-PC load, run, halt detect, watchdog abort.
- Sits between the host/testbench request interface and the core's PC/reset/clock-enable inputs.
- Replaces the core's hard-wired halt compare with a 4-entry program table of start and halt PCs.
- Reports done, timeout and an executed-cycle count.

---
 rtl/core_run_ctrl.sv | 150 +++++++++++++++
 tb/tb_core_run_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/core_run_ctrl.sv
// Run controller for the 9-bit-ISA core: holds the core in reset, loads the start PC,
// runs until the halt PC or the watchdog limit, and reports done/timeout/cycle count.
module core_run_ctrl #(
   parameter int unsigned    PW      = 10,
   parameter int unsigned    CW      = 16,
   parameter int unsigned    RST_CYC = 2,
   parameter logic [CW-1:0]  WDOG    = CW'(50000),
   parameter logic [PW-1:0]  START0  = PW'(0),
   parameter logic [PW-1:0]  START1  = PW'(0),
   parameter logic [PW-1:0]  START2  = PW'(0),
   parameter logic [PW-1:0]  START3  = PW'(0),
   parameter logic [PW-1:0]  HALT0   = PW'(593),
   parameter logic [PW-1:0]  HALT1   = PW'(593),
   parameter logic [PW-1:0]  HALT2   = PW'(593),
   parameter logic [PW-1:0]  HALT3   = PW'(593)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req,
   input  logic          abort,
   input  logic [1:0]    prog_sel,
   input  logic [PW-1:0] core_pc,
   output logic          core_reset,
   output logic          core_run,
   output logic          pc_load,
   output logic [PW-1:0] pc_target,
   output logic          busy,
   output logic          done,
   output logic          timeout,
   output logic [CW-1:0] cycle_cnt
);

   localparam int unsigned HW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HOLD,
      S_LOAD,
      S_RUN,
      S_FIN,
      S_ABORTED
   } state_t;

   state_t        state;
   logic          req_q;
   logic [1:0]    sel_q;
   logic [HW-1:0] hold_cnt;
   logic [PW-1:0] start_pc;
   logic [PW-1:0] halt_pc;
   logic [CW-1:0] cnt_inc;
   logic          start;

   // Program table lookup for the latched selection
   always_comb begin
      start_pc = START0;
      halt_pc  = HALT0;
      case (sel_q)
         2'd1:    begin start_pc = START1; halt_pc = HALT1; end
         2'd2:    begin start_pc = START2; halt_pc = HALT2; end
         2'd3:    begin start_pc = START3; halt_pc = HALT3; end
         default: begin start_pc = START0; halt_pc = HALT0; end
      endcase
   end

   assign start    = req & ~req_q;
   assign cnt_inc  = (&cycle_cnt) ? cycle_cnt : cycle_cnt + CW'(1);
   assign core_run = (state == S_LOAD) || (state == S_RUN);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         req_q      <= 1'b1;
         sel_q      <= 2'd0;
         hold_cnt   <= '0;
         core_reset <= 1'b1;
         pc_load    <= 1'b0;
         pc_target  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         timeout    <= 1'b0;
         cycle_cnt  <= '0;
      end else begin
         req_q   <= req;
         pc_load <= 1'b0;
         case (state)
            S_IDLE, S_FIN, S_ABORTED: begin
               if (start) begin
                  state      <= S_HOLD;
                  sel_q      <= prog_sel;
                  hold_cnt   <= HW'(RST_CYC - 1);
                  core_reset <= 1'b1;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  timeout    <= 1'b0;
                  cycle_cnt  <= '0;
               end
            end
            S_HOLD: begin
               if (abort) begin
                  state      <= S_IDLE;
                  core_reset <= 1'b1;
                  busy       <= 1'b0;
               end else if (hold_cnt == '0) begin
                  state      <= S_LOAD;
                  core_reset <= 1'b0;
                  pc_load    <= 1'b1;
                  pc_target  <= start_pc;
               end else begin
                  hold_cnt <= hold_cnt - HW'(1);
               end
            end
            S_LOAD: begin
               if (abort) begin
                  state      <= S_IDLE;
                  core_reset <= 1'b1;
                  busy       <= 1'b0;
               end else begin
                  state     <= S_RUN;
                  cycle_cnt <= cnt_inc;
               end
            end
            S_RUN: begin
               // Halt compare takes priority over the watchdog in the same cycle
               if (abort) begin
                  state      <= S_IDLE;
                  core_reset <= 1'b1;
                  busy       <= 1'b0;
               end else begin
                  cycle_cnt <= cnt_inc;
                  if (core_pc == halt_pc) begin
                     state <= S_FIN;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else if (cycle_cnt >= WDOG) begin
                     state   <= S_ABORTED;
                     busy    <= 1'b0;
                     timeout <= 1'b1;
                  end
               end
            end
            default: begin
               state      <= S_IDLE;
               core_reset <= 1'b1;
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed bench for core_run_ctrl with a stub core and a scoreboard of expected run results.
module tb_core_run_ctrl;

   localparam int unsigned PW = 10;
   localparam int unsigned CW = 16;

   logic          clk;
   logic          reset;
   logic          req;
   logic          abort;
   logic [1:0]    prog_sel;
   logic [PW-1:0] core_pc;
   logic          core_reset;
   logic          core_run;
   logic          pc_load;
   logic [PW-1:0] pc_target;
   logic          busy;
   logic          done;
   logic          timeout;
   logic [CW-1:0] cycle_cnt;
   logic          pc_stuck;

   typedef struct {
      logic          done;
      logic          timeout;
      logic [CW-1:0] cnt;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   core_run_ctrl #(
      .PW(PW), .CW(CW), .RST_CYC(2), .WDOG(16'd20),
      .START0(10'h100), .HALT0(10'h114),
      .START1(10'h040), .HALT1(10'h045),
      .START2(10'h080), .HALT2(10'h083)
   ) dut (
      .clk(clk), .reset(reset), .req(req), .abort(abort), .prog_sel(prog_sel),
      .core_pc(core_pc), .core_reset(core_reset), .core_run(core_run),
      .pc_load(pc_load), .pc_target(pc_target), .busy(busy), .done(done),
      .timeout(timeout), .cycle_cnt(cycle_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stub core: the load cycle executes the target, so the next presented PC is target+1
   always_ff @(posedge clk) begin
      if (pc_stuck)
         core_pc <= 10'h010;
      else if (core_run)
         core_pc <= (pc_load ? pc_target : core_pc) + PW'(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Edge on req, then two HOLD cycles with core_reset high, then the single LOAD cycle
   task automatic start_run(input logic [1:0] sel, input logic [PW-1:0] exp_start);
      prog_sel = sel;
      req = 1'b1;
      tick();
      req = 1'b0;
      check("hold1_core_reset", 32'(core_reset), 1);
      check("hold1_busy", 32'(busy), 1);
      check("hold1_cleared", 32'({done, timeout, cycle_cnt}), 0);
      tick();
      check("hold2_core_reset", 32'(core_reset), 1);
      check("hold2_pc_load", 32'(pc_load), 0);
      tick();
      check("load_pc_load", 32'(pc_load), 1);
      check("load_pc_target", 32'(pc_target), 32'(exp_start));
      check("load_core_reset", 32'(core_reset), 0);
      check("load_core_run", 32'(core_run), 1);
   endtask

   task automatic wait_cnt(input logic [CW-1:0] target);
      for (int i = 0; i < 100; i++) begin
         if (cycle_cnt == target) break;
         tick();
      end
      check("wait_cnt", 32'(cycle_cnt), 32'(target));
   endtask

   task automatic wait_done();
      exp_t e;
      for (int i = 0; i < 100; i++) begin
         if (!busy) break;
         tick();
      end
      check("end_busy", 32'(busy), 0);
      check("sb_nonempty", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("end_done", 32'(done), 32'(e.done));
         check("end_timeout", 32'(timeout), 32'(e.timeout));
         check("end_cycle_cnt", 32'(cycle_cnt), 32'(e.cnt));
         check("end_core_run", 32'(core_run), 0);
         check("end_core_reset", 32'(core_reset), 0);
      end
   endtask

   initial begin
      reset    = 1'b1;
      req      = 1'b1;
      abort    = 1'b0;
      prog_sel = 2'd0;
      pc_stuck = 1'b0;
      #2 reset = 1'b0;
      #1;
      check("rst_outputs", 32'({core_reset, core_run, pc_load, busy, done, timeout}), 32'b100000);
      check("rst_cnt_target", 32'({cycle_cnt, pc_target}), 0);
      tick();
      tick();
      reset = 1'b1;

      // req held high through reset release must not start a run
      repeat (3) tick();
      check("req_held_busy", 32'(busy), 0);
      check("req_held_core_reset", 32'(core_reset), 1);
      req = 1'b0;
      tick();

      // Basic run with program 1
      sb.push_back('{done: 1'b1, timeout: 1'b0, cnt: 16'd6});
      start_run(2'd1, 10'h040);
      wait_done();

      // Restart from FIN with program 2
      sb.push_back('{done: 1'b1, timeout: 1'b0, cnt: 16'd4});
      start_run(2'd2, 10'h080);
      wait_done();

      // Second edge during RUN is ignored
      sb.push_back('{done: 1'b1, timeout: 1'b0, cnt: 16'd6});
      start_run(2'd1, 10'h040);
      tick();
      prog_sel = 2'd0;
      req = 1'b1;
      tick();
      req = 1'b0;
      check("retrig_busy", 32'(busy), 1);
      wait_done();
      tick();
      check("retrig_not_queued", 32'(busy), 0);

      // Watchdog abort with a stuck PC
      pc_stuck = 1'b1;
      sb.push_back('{done: 1'b0, timeout: 1'b1, cnt: 16'd21});
      start_run(2'd3, 10'h000);
      wait_cnt(16'd20);
      check("wdog_limit_run", 32'(core_run), 1);
      tick();
      check("wdog_after_run", 32'(core_run), 0);
      wait_done();
      pc_stuck = 1'b0;

      // Halt reached exactly at the watchdog limit
      sb.push_back('{done: 1'b1, timeout: 1'b0, cnt: 16'd21});
      start_run(2'd0, 10'h100);
      wait_done();

      // Host abort at cycle 5
      start_run(2'd3, 10'h000);
      wait_cnt(16'd5);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_idle", 32'({busy, core_run, core_reset}), 32'b001);
      check("abort_flags", 32'({done, timeout}), 0);
      check("abort_cnt", 32'(cycle_cnt), 5);
      tick();
      check("abort_cnt_frozen", 32'(cycle_cnt), 5);

      // Asynchronous reset mid-RUN
      start_run(2'd1, 10'h040);
      tick();
      tick();
      check("pre_rst_run", 32'(core_run), 1);
      #2 reset = 1'b0;
      #1;
      check("async_rst_outputs", 32'({core_reset, core_run, pc_load, busy, done, timeout}), 32'b100000);
      check("async_rst_cnt_target", 32'({cycle_cnt, pc_target}), 0);
      #2 reset = 1'b1;
      tick();
      tick();
      check("post_rst_idle", 32'(busy), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
